// File: rtl/uart_tx_fsm_ctrl_if.sv
// ---------------------------------------------------------------------------
// uart_tx_fsm_ctrl_if
// Groups the signals between the UART frame controller, its upstream word
// source and the downstream serializer.
//   Upstream -> ctrl : Data_Valid, P_Data, PAR_EN, PAR_TYP
//   Serializer -> ctrl : Ser_Data, Ser_Done
//   ctrl -> serializer : Ser_En, Ser_Load, P_Data_Out
//   ctrl -> line/status : TX_OUT, Busy, Frame_Err
// slave  : view taken by the frame controller
// master : view taken by the environment (upstream + serializer + line)
// ---------------------------------------------------------------------------
interface uart_tx_fsm_ctrl_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  Data_Valid;
    logic [DATA_WIDTH-1:0] P_Data;
    logic                  PAR_EN;
    logic                  PAR_TYP;
    logic                  Ser_Data;
    logic                  Ser_Done;
    logic                  Ser_En;
    logic                  Ser_Load;
    logic [DATA_WIDTH-1:0] P_Data_Out;
    logic                  TX_OUT;
    logic                  Busy;
    logic                  Frame_Err;

    modport slave (
        input  Data_Valid, P_Data, PAR_EN, PAR_TYP, Ser_Data, Ser_Done,
        output Ser_En, Ser_Load, P_Data_Out, TX_OUT, Busy, Frame_Err
    );

    modport master (
        output Data_Valid, P_Data, PAR_EN, PAR_TYP, Ser_Data, Ser_Done,
        input  Ser_En, Ser_Load, P_Data_Out, TX_OUT, Busy, Frame_Err
    );
endinterface

// File: rtl/uart_tx_fsm_ctrl.sv
// ---------------------------------------------------------------------------
// uart_tx_fsm_ctrl
// Frame controller for the UART transmitter. Accepts a parallel word, drives
// the serializer (load/enable) and muxes start, data, parity and stop bits
// onto TX_OUT. A DATA phase that never sees Ser_Done is aborted after
// DONE_TMO cycles with a one-cycle Frame_Err pulse.
// Ports:
//   clk  : transmit clock, one bit per cycle
//   RST  : asynchronous active-low reset
//   bus  : uart_tx_fsm_ctrl_if.slave (handshake, serializer and line signals)
//
// state  | meaning
// -------+-----------------------------------------------------------------
// IDLE   | line high, waiting for Data_Valid; word/config latched on accept
// START  | start bit (0), serializer load pulse, timeout counter cleared
// DATA   | serializer enabled, line follows Ser_Data, timeout counting
// PARITY | latched parity bit on the line
// STOP   | stop bit (1), then back to IDLE
// ---------------------------------------------------------------------------
module uart_tx_fsm_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int DONE_TMO   = 10
) (
    input logic                clk,
    input logic                RST,
    uart_tx_fsm_ctrl_if.slave  bus
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    localparam int              CNT_W    = (DONE_TMO > 1) ? $clog2(DONE_TMO) : 1;
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(DONE_TMO - 1);

    logic [2:0]            state_q, state_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  par_en_q, par_en_d;
    logic                  parity_q, parity_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;

    logic                  timeout;

    // Ser_Done has priority over the timeout when both land in one cycle.
    assign timeout = (state_q == S_DATA) && (cnt_q == TMO_LAST) && !bus.Ser_Done;

    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        par_en_d = par_en_q;
        parity_d = parity_q;
        cnt_d    = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (bus.Data_Valid) begin
                    data_d   = bus.P_Data;
                    par_en_d = bus.PAR_EN;
                    // PAR_TYP folded in here so only one parity bit is kept
                    parity_d = (^bus.P_Data) ^ bus.PAR_TYP;
                    state_d  = S_START;
                end
            end
            S_START: begin
                cnt_d   = '0;
                state_d = S_DATA;
            end
            S_DATA: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (bus.Ser_Done) begin
                    state_d = par_en_q ? S_PARITY : S_STOP;
                end else if (timeout) begin
                    state_d = S_STOP;
                end
            end
            S_PARITY: state_d = S_STOP;
            S_STOP:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            state_q  <= S_IDLE;
            data_q   <= '0;
            par_en_q <= 1'b0;
            parity_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            data_q   <= data_d;
            par_en_q <= par_en_d;
            parity_q <= parity_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        bus.TX_OUT   = 1'b1;
        bus.Busy     = 1'b1;
        bus.Ser_En   = 1'b0;
        bus.Ser_Load = 1'b0;
        case (state_q)
            S_IDLE:   bus.Busy = 1'b0;
            S_START: begin
                bus.TX_OUT   = 1'b0;
                bus.Ser_Load = 1'b1;
            end
            S_DATA: begin
                bus.TX_OUT = bus.Ser_Data;
                bus.Ser_En = 1'b1;
            end
            S_PARITY: bus.TX_OUT = parity_q;
            S_STOP:   bus.TX_OUT = 1'b1;
            default: begin
                bus.TX_OUT = 1'b1;
                bus.Busy   = 1'b0;
            end
        endcase
    end

    assign bus.Frame_Err  = timeout;
    assign bus.P_Data_Out = data_q;

endmodule

// File: tb/tb_uart_tx_fsm_ctrl.sv
module tb_uart_tx_fsm_ctrl;
    localparam int W   = 8;
    localparam int TMO = 10;

    logic clk = 1'b0;
    logic RST;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    uart_tx_fsm_ctrl_if #(.DATA_WIDTH(W)) bus ();

    uart_tx_fsm_ctrl #(.DATA_WIDTH(W), .DONE_TMO(TMO)) dut (
        .clk (clk),
        .RST (RST),
        .bus (bus.slave)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Runs one frame. done_at = DATA-cycle index at which the serializer
    // raises Ser_Done (>= TMO means never). Entered just after a negedge
    // with the DUT idle; returns just after a negedge with the DUT idle.
    task automatic run_frame(input logic [W-1:0] d, input bit pen, input bit ptyp,
                             input int done_at, input bit glitch);
        bit              expq[$];
        bit              obsq[$];
        int              n_data, load_cnt, load_pos, err_cnt, err_pos, exp_err_pos;
        bit              err, ended;
        logic [W-1:0]    ser_word;
        int              ser_idx;

        // reference frame built straight from the frame rules
        err    = (done_at >= TMO);
        n_data = err ? TMO : done_at + 1;
        expq.push_back(1'b0);
        for (int i = 0; i < n_data; i++) expq.push_back(d[i % W]);
        if (pen && !err) expq.push_back(bit'(($countones(d) % 2) == 1) ^ ptyp);
        expq.push_back(1'b1);
        exp_err_pos = err ? n_data : -1;

        load_cnt = 0; load_pos = -1; err_cnt = 0; err_pos = -1;
        ser_word = '0; ser_idx = 0; ended = 0;

        bus.Data_Valid = 1'b1;
        bus.P_Data     = d;
        bus.PAR_EN     = pen;
        bus.PAR_TYP    = ptyp;
        @(negedge clk);
        bus.Data_Valid = 1'b0;
        // mid-frame config/data changes must have no effect
        bus.P_Data  = W'($urandom);
        bus.PAR_EN  = 1'($urandom);
        bus.PAR_TYP = 1'($urandom);

        for (int cyc = 0; cyc < 40; cyc++) begin
            if (bus.Ser_En) begin
                bus.Ser_Data = ser_word[ser_idx % W];
                bus.Ser_Done = (ser_idx == done_at);
                ser_idx++;
            end else begin
                if (bus.Ser_Load) begin
                    ser_word = bus.P_Data_Out;
                    ser_idx  = 0;
                end
                bus.Ser_Data = 1'($urandom);
                bus.Ser_Done = 1'($urandom);
            end
            if (glitch && cyc == 3) begin
                bus.Data_Valid = 1'b1;
                bus.P_Data     = '1;
            end
            if (glitch && cyc == 4) bus.Data_Valid = 1'b0;
            #1;
            if (!bus.Busy) begin
                ended = 1;
                break;
            end
            if (cyc == 0) chk("p_data_out", 32'(bus.P_Data_Out), 32'(d));
            obsq.push_back(bus.TX_OUT);
            if (bus.Ser_Load) begin load_cnt++; load_pos = cyc; end
            if (bus.Frame_Err) begin err_cnt++; err_pos = cyc; end
            @(negedge clk);
        end

        chk("frame_end", 32'(ended), 32'd1);
        chk("busy_len", 32'(obsq.size()), 32'(expq.size()));
        for (int i = 0; i < expq.size() && i < obsq.size(); i++)
            chk($sformatf("tx_bit%0d", i), 32'(obsq[i]), 32'(expq[i]));
        chk("ser_load_cnt", 32'(load_cnt), 32'd1);
        chk("ser_load_pos", 32'(load_pos), 32'd0);
        chk("frame_err_cnt", 32'(err_cnt), err ? 32'd1 : 32'd0);
        chk("frame_err_pos", 32'(err_pos), 32'(exp_err_pos));

        // one idle cycle: nothing queued, line high
        bus.Ser_Done = 1'($urandom);
        @(negedge clk);
        #1;
        chk("idle_busy", 32'(bus.Busy), 32'd0);
        chk("idle_tx", 32'(bus.TX_OUT), 32'd1);
    endtask

    initial begin
        RST            = 1'b0;
        bus.Data_Valid = 1'b0;
        bus.P_Data     = '0;
        bus.PAR_EN     = 1'b0;
        bus.PAR_TYP    = 1'b0;
        bus.Ser_Data   = 1'b0;
        bus.Ser_Done   = 1'b0;
        #1;
        chk("rst_tx", 32'(bus.TX_OUT), 32'd1);
        chk("rst_busy", 32'(bus.Busy), 32'd0);
        chk("rst_ser_en", 32'(bus.Ser_En), 32'd0);
        chk("rst_ser_load", 32'(bus.Ser_Load), 32'd0);
        chk("rst_frame_err", 32'(bus.Frame_Err), 32'd0);
        chk("rst_pdo", 32'(bus.P_Data_Out), 32'd0);
        @(negedge clk);
        @(negedge clk);
        RST = 1'b1;
        #1;

        // reset while in DATA
        bus.Data_Valid = 1'b1;
        bus.P_Data     = 8'hA5;
        bus.PAR_EN     = 1'b1;
        @(negedge clk);
        bus.Data_Valid = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("pre_rst_ser_en", 32'(bus.Ser_En), 32'd1);
        #1;
        RST = 1'b0;
        #1;
        chk("mid_rst_tx", 32'(bus.TX_OUT), 32'd1);
        chk("mid_rst_busy", 32'(bus.Busy), 32'd0);
        chk("mid_rst_ser_en", 32'(bus.Ser_En), 32'd0);
        chk("mid_rst_frame_err", 32'(bus.Frame_Err), 32'd0);
        chk("mid_rst_pdo", 32'(bus.P_Data_Out), 32'd0);
        @(negedge clk);
        RST = 1'b1;
        #1;
        chk("post_rst_busy", 32'(bus.Busy), 32'd0);

        run_frame(8'hA5, 1'b1, 1'b0, W - 1, 1'b0);
        run_frame(8'hA5, 1'b1, 1'b1, W - 1, 1'b0);
        run_frame(8'h01, 1'b1, 1'b0, W - 1, 1'b0);
        run_frame(8'h3C, 1'b0, 1'b0, W - 1, 1'b0);
        run_frame(8'h00, 1'b1, 1'b0, W - 1, 1'b1);
        run_frame(8'h5A, 1'b1, 1'b0, 1000, 1'b0);
        run_frame(8'hC3, 1'b1, 1'b1, TMO - 1, 1'b0);
        run_frame(8'h96, 1'b0, 1'b0, 1000, 1'b0);

        for (int n = 0; n < 25; n++) begin
            int da;
            da = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, TMO + 2)) : W - 1;
            run_frame(W'($urandom), 1'($urandom), 1'($urandom), da, 1'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
